// File: rtl/block_memory_dp.sv
// Simple-dual-port synchronous RAM: byte-enabled write port, pipelined read port,
// selectable read-during-write policy and a post-reset zeroing sweep.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | sweeping zeros through the array, user requests ignored
// ST_READY | normal operation; left only through rst
module block_memory_dp #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int READ_LATENCY   = 1,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    busy,
  input  logic                    a_we,
  input  logic [DATA_WIDTH/8-1:0] a_be,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  input  logic                    b_re,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    b_rvalid
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if ((DATA_WIDTH % 8) != 0 || (READ_LATENCY != 1 && READ_LATENCY != 2)) begin : g_param_err
    $error("block_memory_dp: DATA_WIDTH must be a multiple of 8 and READ_LATENCY 1 or 2");
  end

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  rd1_valid_q, rd1_valid_d;
  logic [DATA_WIDTH-1:0] rd1_data_q, rd1_data_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we, wr_en, rd_en;
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_we     = 1'b0;
    busy       = (state_q == ST_CLEAR);
    wr_en      = !busy && !rst && a_we;
    rd_en      = !busy && b_re;
    case (state_q)
      ST_CLEAR: begin
        clr_we     = !rst;
        clr_addr_d = clr_addr_q + 1'b1;
        if (&clr_addr_q) state_d = ST_READY;
      end
      default: ;
    endcase

    // Write-first collisions forward the enabled bytes of the incoming write.
    rd_word = mem[b_addr];
    if (WRITE_MODE == 1 && wr_en && a_addr == b_addr) begin
      for (int i = 0; i < NB; i++) begin
        if (a_be[i]) rd_word[8*i +: 8] = a_wdata[8*i +: 8];
      end
    end

    rd1_valid_d = rd_en;
    rd1_data_d  = rd_en ? rd_word : rd1_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_addr_q  <= '0;
      rd1_valid_q <= 1'b0;
      rd1_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      rd1_valid_q <= rd1_valid_d;
      rd1_data_q  <= rd1_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (a_be[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  rd2_valid_q, rd2_valid_d;
    logic [DATA_WIDTH-1:0] rd2_data_q, rd2_data_d;

    always_comb begin
      rd2_valid_d = rd1_valid_q;
      rd2_data_d  = rd1_valid_q ? rd1_data_q : rd2_data_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd2_valid_q <= 1'b0;
        rd2_data_q  <= '0;
      end else begin
        rd2_valid_q <= rd2_valid_d;
        rd2_data_q  <= rd2_data_d;
      end
    end

    assign b_rvalid = rd2_valid_q;
    assign b_rdata  = rd2_data_q;
  end else begin : g_lat1
    assign b_rvalid = rd1_valid_q;
    assign b_rdata  = rd1_data_q;
  end

endmodule

// File: tb/tb_block_memory_dp.sv
// Bench for block_memory_dp: two 16-word instances (latency 1 read-first, latency 2
// write-first) share stimulus and are checked against a queue-based reference model.
module tb_block_memory_dp;

  logic        clk = 1'b0;
  logic        rst, a_we, b_re;
  logic [3:0]  a_be, a_addr, b_addr;
  logic [31:0] a_wdata;
  logic        busy0, busy1, v0, v1;
  logic [31:0] d0, d1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  block_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .WRITE_MODE(0),
                    .CLEAR_ON_RESET(1)) u_rl1 (
    .clk(clk), .rst(rst), .busy(busy0), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
    .a_wdata(a_wdata), .b_re(b_re), .b_addr(b_addr), .b_rdata(d0), .b_rvalid(v0));

  block_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .WRITE_MODE(1),
                    .CLEAR_ON_RESET(1)) u_rl2 (
    .clk(clk), .rst(rst), .busy(busy1), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
    .a_wdata(a_wdata), .b_re(b_re), .b_addr(b_addr), .b_rdata(d1), .b_rvalid(v1));

  // Reference model: word array plus per-instance queues of {due cycle, data}.
  typedef struct { int due; logic [31:0] d; } tok_t;
  tok_t        q0[$], q1[$];
  logic [31:0] mem_m [16];
  int          clr_m, cyc;
  bit          busy_m;
  logic        exp_v0, exp_v1;
  logic [31:0] exp_d0, exp_d1;

  typedef struct {
    logic we; logic [3:0] be; logic [3:0] wa; logic [31:0] wd;
    logic re; logic [3:0] ra; logic ev; logic [31:0] ed;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [31:0] old_w, new_w;
    cyc++;
    exp_v0 = 1'b0;
    exp_v1 = 1'b0;
    if (rst) begin
      busy_m = 1'b1;
      clr_m  = 0;
      q0.delete();
      q1.delete();
      exp_d0 = '0;
      exp_d1 = '0;
      return;
    end
    if (busy_m) begin
      mem_m[clr_m] = '0;
      clr_m++;
      if (clr_m == 16) busy_m = 1'b0;
    end else begin
      old_w = mem_m[b_addr];
      new_w = old_w;
      for (int i = 0; i < 4; i++)
        if (a_be[i]) new_w[8*i +: 8] = a_wdata[8*i +: 8];
      if (b_re) begin
        q0.push_back('{due: cyc, d: old_w});
        q1.push_back('{due: cyc + 1, d: (a_we && a_addr == b_addr) ? new_w : old_w});
      end
      if (a_we) mem_m[a_addr] = (a_addr == b_addr) ? new_w : apply_be(mem_m[a_addr]);
    end
    if (q0.size() > 0 && q0[0].due == cyc) begin
      exp_v0 = 1'b1;
      exp_d0 = q0.pop_front().d;
    end
    if (q1.size() > 0 && q1[0].due == cyc) begin
      exp_v1 = 1'b1;
      exp_d1 = q1.pop_front().d;
    end
  endtask

  function automatic logic [31:0] apply_be(input logic [31:0] w);
    logic [31:0] r;
    r = w;
    for (int i = 0; i < 4; i++)
      if (a_be[i]) r[8*i +: 8] = a_wdata[8*i +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("busy_rl1", {31'd0, busy0}, {31'd0, busy_m});
    chk("busy_rl2", {31'd0, busy1}, {31'd0, busy_m});
    chk("rvalid_rl1", {31'd0, v0}, {31'd0, exp_v0});
    chk("rvalid_rl2", {31'd0, v1}, {31'd0, exp_v1});
    chk("rdata_rl1", d0, exp_d0);
    chk("rdata_rl2", d1, exp_d1);
  endtask

  task automatic idle_inputs();
    a_we = 1'b0; a_be = '0; a_addr = '0; a_wdata = '0; b_re = 1'b0; b_addr = '0;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (busy0 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    a_we = 1'b1; a_be = 4'hF; a_addr = addr; a_wdata = data;
    tick();
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt0, cnt1, bad, first_idx;
    logic [31:0] got[$];
    logic [31:0] lat_exp[4];

    tbl[0] = '{1, 4'hF, 4'd3, 32'hAABBCCDD, 0, 4'd0, 0, 32'h0};
    tbl[1] = '{1, 4'h5, 4'd3, 32'h11223344, 0, 4'd0, 0, 32'h0};
    tbl[2] = '{0, 4'h0, 4'd0, 32'h0,        1, 4'd3, 1, 32'hAA22CC44};
    tbl[3] = '{0, 4'h0, 4'd0, 32'h0,        0, 4'd0, 0, 32'hAA22CC44};
    tbl[4] = '{1, 4'hF, 4'd5, 32'h1,        1, 4'd3, 1, 32'hAA22CC44};
    tbl[5] = '{1, 4'hF, 4'd5, 32'h2,        1, 4'd5, 1, 32'h1};
    tbl[6] = '{0, 4'h0, 4'd0, 32'h0,        1, 4'd5, 1, 32'h2};
    tbl[7] = '{1, 4'h0, 4'd5, 32'hFFFFFFFF, 1, 4'd5, 1, 32'h2};
    tbl[8] = '{0, 4'h0, 4'd0, 32'h0,        1, 4'd5, 1, 32'h2};
    tbl[9] = '{0, 4'h0, 4'd0, 32'h0,        0, 4'd0, 0, 32'h2};

    cyc = 0; busy_m = 1'b1; clr_m = 0;
    idle_inputs();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // Clear sweep with requests held during busy.
    a_we = 1'b1; a_be = 4'hF; a_addr = 4'd0; a_wdata = 32'hFFFFFFFF;
    b_re = 1'b1; b_addr = 4'd0;
    n = 0; bad = 0;
    while (busy0 && n < 100) begin
      n++;
      tick();
      if (busy0 && (v0 || v1)) bad++;
      if (v0 || v1) bad += (n <= 16) ? 1 : 0;
    end
    idle_inputs();
    chk("clear_busy_cycles", n, 16);
    chk("rvalid_during_busy", bad, 0);

    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 16; i++) begin
      b_re = 1'b1; b_addr = 4'(i);
      tick();
      cnt0 += v0; cnt1 += v1;
    end
    idle_inputs();
    repeat (2) begin
      tick();
      cnt0 += v0; cnt1 += v1;
    end
    chk("clear_read_pulses_rl1", cnt0, 16);
    chk("clear_read_pulses_rl2", cnt1, 16);

    for (int i = 0; i < 10; i++) begin
      a_we = tbl[i].we; a_be = tbl[i].be; a_addr = tbl[i].wa; a_wdata = tbl[i].wd;
      b_re = tbl[i].re; b_addr = tbl[i].ra;
      tick();
      chk($sformatf("tbl%0d_rvalid", i), {31'd0, v0}, {31'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_rdata", i), d0, tbl[i].ed);
    end
    idle_inputs();

    // Latency-2 burst on preloaded words.
    lat_exp[0] = 32'd10; lat_exp[1] = 32'd20; lat_exp[2] = 32'd30; lat_exp[3] = 32'd40;
    for (int i = 0; i < 4; i++) wr(4'(i), lat_exp[i]);
    first_idx = -1;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin b_re = 1'b1; b_addr = 4'(k); end
      else idle_inputs();
      tick();
      if (v1) begin
        if (first_idx < 0) first_idx = k;
        got.push_back(d1);
      end
    end
    chk("rl2_first_pulse_idx", first_idx, 1);
    chk("rl2_pulse_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("rl2_order%0d", i), got[i], lat_exp[i]);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      a_we = 1'($urandom_range(0, 1)); a_be = 4'($urandom); a_addr = 4'($urandom);
      a_wdata = $urandom; b_re = 1'($urandom_range(0, 1));
      b_addr = ($urandom_range(0, 3) == 0) ? a_addr : 4'($urandom);
      tick();
    end
    idle_inputs();
    repeat (3) tick();

    // Reset restart mid-clear.
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (7) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    wait_clear(n);
    chk("restart_busy_cycles", n, 16);

    // Reset with a read in flight.
    wr(4'd3, 32'hDEADBEEF);
    b_re = 1'b1; b_addr = 4'd3;
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    chk("midread_rvalid_rl2", {31'd0, v1}, 32'd0);
    chk("midread_rdata_rl2", d1, 32'd0);
    rst = 1'b0;
    wait_clear(n);
    chk("midread_busy_cycles", n, 16);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/block_memory_dp.md
Name: block_memory_dp

Overview:
Parametrised simple-dual-port synchronous RAM: one write port with byte enables, one read port with a valid strobe. Successor to the single-port 32-bit block memory in the CPU core. Used for data memory and register-file-style storage. Adds configurable width/depth, 1- or 2-cycle read latency, a selectable read-during-write policy, and a hardware clear sequence after reset.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
ADDR_WIDTH, 10, address bits; DEPTH = 2**ADDR_WIDTH words
READ_LATENCY, 1, edges from accepted read to b_rvalid; legal values 1 or 2
WRITE_MODE, 0, same-address read/write collision: 0 = read-first (old data), 1 = write-first (new data)
CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = no clear, contents undefined

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
busy  out  1  clear sequence in progress; user requests ignored
a_we  in  1  write request
a_be  in  DATA_WIDTH/8  byte enables; bit i covers a_wdata[8i+7:8i]
a_addr  in  ADDR_WIDTH  write address
a_wdata  in  DATA_WIDTH  write data
b_re  in  1  read request
b_addr  in  ADDR_WIDTH  read address
b_rdata  out  DATA_WIDTH  read data, valid when b_rvalid=1
b_rvalid  out  1  one-cycle pulse per accepted read

Behaviour:
- Reset (rst=1 at an edge): b_rvalid=0, b_rdata=0, all read-pipeline valids cleared. If CLEAR_ON_RESET=1: state<=CLEAR, clr_addr<=0, busy=1. If 0: state<=READY, busy=0. Memory array itself is not reset.
- FSM states: CLEAR, READY.
- CLEAR: each edge with rst=0 writes 0 to mem[clr_addr] and increments clr_addr. The edge that writes DEPTH-1 moves state to READY and clears busy. busy is therefore high for exactly DEPTH cycles after rst falls.
- rst asserted during CLEAR restarts the sweep at address 0.
- While busy=1, a_we and b_re are ignored. No memory update, no b_rvalid.
- READY has no exit except rst.
- Write: at an edge with busy=0, a_we=1: bytes with a_be[i]=1 are updated; other bytes are unchanged. If a_be is all zero, nothing is written.
- Read, READY only. A read is accepted at edge N when b_re=1 and busy=0.
  - READ_LATENCY=1: b_rdata and b_rvalid=1 are presented after edge N.
  - READ_LATENCY=2: data is registered once more; output appears after edge N+1.
  - Back-to-back reads every cycle are supported; throughput is 1 read per cycle.
- b_rvalid is high for exactly one cycle per accepted read. b_rdata holds its last value while b_rvalid=0.
- Collision: a_we=1 and b_re=1 at the same edge with a_addr==b_addr.
  - WRITE_MODE=0: the read returns the pre-write word.
  - WRITE_MODE=1: the read returns the merged word: enabled bytes from a_wdata, other bytes old.
  - Different addresses: the two ports are independent.
- A write to address X at edge N followed by a read of X accepted at edge N+1 always returns the new data.
- Reset mid-read drops in-flight reads: no b_rvalid is produced for them.
- Addresses cover the full 2**ADDR_WIDTH range, so no out-of-range case exists.
- Parameter check: an elaboration-time error is required if DATA_WIDTH%8!=0 or READ_LATENCY is not 1 or 2.

Test Plan:
- Clear: ADDR_WIDTH=4, rst for 2 cycles then release -> busy=1 for exactly 16 cycles. Then reading all 16 addresses returns 0x00000000 with one b_rvalid per read.
- Byte enables: write 0xAABBCCDD to addr 3 with a_be=4'b1111, then 0x11223344 with a_be=4'b0101 -> read addr 3 returns 0xAA22CC44.
- Latency and throughput: READ_LATENCY=2, b_re high for 4 consecutive cycles on addrs 0..3 preloaded with 10,20,30,40 -> b_rvalid high for 4 cycles. The first pulse comes 2 edges after the first request; data arrives in order 10,20,30,40.
- Collision: addr 5 holds 0x1, same-edge write 0x2 with full a_be and read of addr 5 -> WRITE_MODE=0 returns 0x1; WRITE_MODE=1 returns 0x2. The following read returns 0x2 in both modes.
- Busy gating: assert a_we to addr 0 with 0xFFFFFFFF and b_re mid-clear -> no b_rvalid during busy. After clear completes, addr 0 reads 0.
- Reset mid-clear and mid-read: rst pulse at clear cycle 7 -> busy held for DEPTH full cycles after release. rst pulse with a read in flight (READ_LATENCY=2) -> no b_rvalid, and b_rdata=0.
